// File: rtl/sonar_echo_responder.sv
// HC-SR04-compatible responder: accepts a trigger pulse and answers with an echo whose width encodes distance_cm.
// Optional macro SONAR_JITTER_EN adds 0..3 cm of LFSR jitter to the latched distance.
module sonar_echo_responder #(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned TRIG_MIN_US    = 10,
    parameter int unsigned BURST_DELAY_US = 250,
    parameter int unsigned US_PER_CM      = 58,
    parameter int unsigned MAX_CM         = 400,
    parameter int unsigned TIMEOUT_US     = 38000,
    parameter int unsigned HOLDOFF_US     = 60000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       trigger_in,
    input  logic [8:0] distance_cm,
    output logic       echo_out,
    output logic       busy,
    output logic       trig_err,
    output logic [7:0] meas_count
);
    localparam int unsigned CYC_PER_US = CLK_HZ / 1000000;
    localparam int unsigned PW = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(CYC_PER_US - 1);
    localparam logic [15:0] TRIG_MIN    = 16'(TRIG_MIN_US);
    localparam logic [15:0] BURST_LAST  = 16'(BURST_DELAY_US - 1);
    localparam logic [15:0] HOLD_LAST   = 16'(HOLDOFF_US - 1);
    localparam logic [15:0] TIMEOUT_W   = 16'(TIMEOUT_US);
    localparam logic [15:0] UPC         = 16'(US_PER_CM);
    localparam logic [15:0] MAX_D       = 16'(MAX_CM);

    typedef enum logic [2:0] {IDLE, TRIG, BURST, ECHO, HOLDOFF} state_t;
    state_t state, state_nx;

    logic          trig_s1, trig_s2, trig_d;
    logic          rise, fall, tick, trig_ok, accept;
    logic [PW-1:0] pre;
    logic [15:0]   us_cnt;
    logic [8:0]    d_lat;
    logic [15:0]   d_eff;
    logic [15:0]   w_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_d  <= 1'b0;
        end else begin
            trig_s1 <= trigger_in;
            trig_s2 <= trig_s1;
            trig_d  <= trig_s2;
        end
    end

    assign rise = trig_s2 & ~trig_d;
    assign fall = ~trig_s2 & trig_d;
    assign tick = (pre == PRE_LAST);

    // The final microsecond of the trigger completes on the same cycle the fall is seen.
    assign trig_ok = (us_cnt >= TRIG_MIN) || (tick && (us_cnt == TRIG_MIN - 16'd1));
    assign accept  = (state == TRIG) && enable && fall && trig_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre    <= '0;
            us_cnt <= '0;
        end else if (state_nx != state) begin
            pre    <= '0;
            us_cnt <= '0;
        end else if (tick) begin
            pre <= '0;
            if (us_cnt != '1) us_cnt <= us_cnt + 16'd1;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_lat      <= '0;
            meas_count <= '0;
        end else if (accept) begin
            d_lat      <= distance_cm;
            meas_count <= meas_count + 8'd1;
        end
    end

`ifdef SONAR_JITTER_EN
    logic [7:0] lfsr, lfsr_nx;
    logic [1:0] jit;
    assign lfsr_nx = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= 8'hA5;
            jit  <= '0;
        end else if (accept) begin
            lfsr <= lfsr_nx;
            jit  <= lfsr_nx[1:0];
        end
    end
    assign d_eff = {7'b0, d_lat} + {14'b0, jit};
`else
    assign d_eff = {7'b0, d_lat};
`endif

    always_comb begin
        if ((d_lat == '0) || (d_eff > MAX_D)) w_last = TIMEOUT_W - 16'd1;
        else                                  w_last = (d_eff * UPC) - 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable && rise) state_nx = TRIG;
            TRIG:    if (!enable) state_nx = IDLE;
                     else if (fall) state_nx = trig_ok ? BURST : IDLE;
            BURST:   if (!enable) state_nx = IDLE;
                     else if (tick && (us_cnt == BURST_LAST)) state_nx = ECHO;
            ECHO:    if (!enable) state_nx = IDLE;
                     else if (tick && (us_cnt == w_last)) state_nx = HOLDOFF;
            HOLDOFF: if (!enable) state_nx = IDLE;
                     else if (tick && (us_cnt == HOLD_LAST)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        echo_out = (state == ECHO);
        busy     = (state != IDLE);
        trig_err = (state == TRIG) && enable && fall && !trig_ok;
    end
endmodule

// File: tb/tb_sonar_echo_responder.sv
// Randomized self-checking bench for sonar_echo_responder using scaled-down timing parameters.
module tb_sonar_echo_responder;
    localparam int CLK_HZ  = 2000000;
    localparam int CYC     = CLK_HZ / 1000000;
    localparam int TMIN    = 10;
    localparam int BURST   = 20;
    localparam int UPC     = 3;
    localparam int MAXCM   = 400;
    localparam int TOUT    = 1500;
    localparam int HOLD    = 200;
    localparam int LAT     = BURST * CYC + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       trigger_in = 1'b0;
    logic [8:0] distance_cm = '0;
    logic       echo_out, busy, trig_err;
    logic [7:0] meas_count;

    int checks = 0;
    int passes = 0;
    int m_meas = 0;
    logic [7:0] m_lfsr = 8'hA5;

    sonar_echo_responder #(
        .CLK_HZ(CLK_HZ), .TRIG_MIN_US(TMIN), .BURST_DELAY_US(BURST), .US_PER_CM(UPC),
        .MAX_CM(MAXCM), .TIMEOUT_US(TOUT), .HOLDOFF_US(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .trigger_in(trigger_in),
        .distance_cm(distance_cm), .echo_out(echo_out), .busy(busy),
        .trig_err(trig_err), .meas_count(meas_count)
    );

    always #5 clk = ~clk;

    // Reference: records an accepted measurement and returns the echo width in µs.
    function automatic int accept_model(input int d);
        int eff;
        eff = d;
        m_meas = (m_meas + 1) % 256;
`ifdef SONAR_JITTER_EN
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        eff = d + int'(m_lfsr[1:0]);
`endif
        if (d == 0 || eff > MAXCM) return TOUT;
        return eff * UPC;
    endfunction

    task automatic send_trig(input int n);
        @(negedge clk);
        trigger_in = 1'b1;
        repeat (n) @(negedge clk);
        trigger_in = 1'b0;
    endtask

    task automatic wait_rise(output int lat);
        lat = -1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (echo_out) begin lat = i; break; end
        end
    endtask

    task automatic measure_echo(output int lat, output int width);
        width = -1;
        wait_rise(lat);
        if (lat > 0) begin
            for (int i = 1; i <= 5000; i++) begin
                @(posedge clk); #1;
                if (!echo_out) begin width = i; break; end
            end
        end
    endtask

    task automatic wait_idle(output int cyc);
        cyc = -1;
        for (int i = 0; i <= 5000; i++) begin
            if (!busy) begin cyc = i; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        #1;
        checks++; if (echo_out !== 1'b0) $display("FAIL reset_echo got %b want 0", echo_out); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
        checks++; if (trig_err !== 1'b0) $display("FAIL reset_err got %b want 0", trig_err); else passes++;
        checks++; if (meas_count !== 8'd0) $display("FAIL reset_meas got %0d want 0", meas_count); else passes++;
    endtask

    task automatic test_basic;
        int w, lat, wid, c;
        distance_cm = 9'd10;
        w = accept_model(10);
        send_trig(12 * CYC);
        measure_echo(lat, wid);
        checks++; if (lat !== LAT) $display("FAIL basic_latency got %0d want %0d", lat, LAT); else passes++;
        checks++; if (wid !== w * CYC) $display("FAIL basic_width got %0d want %0d", wid, w * CYC); else passes++;
        checks++; if (meas_count !== 8'(m_meas)) $display("FAIL basic_meas got %0d want %0d", meas_count, m_meas); else passes++;
        wait_idle(c);
        checks++; if (c !== HOLD * CYC) $display("FAIL basic_holdoff got %0d want %0d", c, HOLD * CYC); else passes++;
    endtask

    task automatic short_trig(input int n, input string tag);
        int errs, c;
        logic seen;
        errs = 0; seen = 1'b0;
        distance_cm = 9'($urandom_range(1, 400));
        send_trig(n);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            errs += int'(trig_err);
            seen |= echo_out;
        end
        checks++; if (errs !== 1) $display("FAIL %s_err got %0d want 1", tag, errs); else passes++;
        checks++; if (seen !== 1'b0) $display("FAIL %s_echo got %b want 0", tag, seen); else passes++;
        checks++; if (meas_count !== 8'(m_meas)) $display("FAIL %s_meas got %0d want %0d", tag, meas_count, m_meas); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL %s_busy got %b want 0", tag, busy); else passes++;
    endtask

    task automatic test_short;
        int w, lat, wid, c;
        short_trig(5 * CYC, "short5us");
        short_trig(TMIN * CYC - 1, "short_min_minus");
        distance_cm = 9'd7;
        w = accept_model(7);
        send_trig(TMIN * CYC);
        measure_echo(lat, wid);
        checks++; if (lat !== LAT) $display("FAIL exact_min_latency got %0d want %0d", lat, LAT); else passes++;
        checks++; if (wid !== w * CYC) $display("FAIL exact_min_width got %0d want %0d", wid, w * CYC); else passes++;
        wait_idle(c);
    endtask

    task automatic test_range;
        int ds[5] = '{0, 450, 400, 401, 1};
        int w, lat, wid, c;
        foreach (ds[k]) begin
            distance_cm = 9'(ds[k]);
            w = accept_model(ds[k]);
            send_trig(TMIN * CYC);
            measure_echo(lat, wid);
            checks++; if (wid !== w * CYC) $display("FAIL range_d%0d_width got %0d want %0d", ds[k], wid, w * CYC); else passes++;
            wait_idle(c);
        end
    endtask

    task automatic test_holdoff;
        int w, lat, wid, c, errs;
        logic seen;
        errs = 0; seen = 1'b0;
        distance_cm = 9'd10;
        w = accept_model(10);
        send_trig(24);
        measure_echo(lat, wid);
        repeat (100) @(posedge clk);
        send_trig(24);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            errs += int'(trig_err);
            seen |= echo_out;
        end
        checks++; if (seen !== 1'b0) $display("FAIL holdoff_echo got %b want 0", seen); else passes++;
        checks++; if (errs !== 0) $display("FAIL holdoff_err got %0d want 0", errs); else passes++;
        checks++; if (meas_count !== 8'(m_meas)) $display("FAIL holdoff_meas got %0d want %0d", meas_count, m_meas); else passes++;
        wait_idle(c);
        w = accept_model(10);
        send_trig(24);
        measure_echo(lat, wid);
        checks++; if (lat !== LAT) $display("FAIL after_holdoff_latency got %0d want %0d", lat, LAT); else passes++;
        checks++; if (wid !== w * CYC) $display("FAIL after_holdoff_width got %0d want %0d", wid, w * CYC); else passes++;
        wait_idle(c);
    endtask

    task automatic test_latch_enable;
        int w, lat, cnt, c, errs;
        logic seen, bseen;
        distance_cm = 9'd10;
        w = accept_model(10);
        send_trig(24);
        wait_rise(lat);
        cnt = 0;
        for (int i = 1; i <= 5000; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 10) distance_cm = 9'd100;
            if (!echo_out) break;
        end
        checks++; if (cnt !== w * CYC) $display("FAIL latch_width got %0d want %0d", cnt, w * CYC); else passes++;
        wait_idle(c);

        distance_cm = 9'd50;
        w = accept_model(50);
        send_trig(24);
        wait_rise(lat);
        repeat (5) @(posedge clk);
        @(negedge clk); enable = 1'b0;
        @(posedge clk); #1;
        checks++; if (echo_out !== 1'b0) $display("FAIL en_drop_echo got %b want 0", echo_out); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL en_drop_busy got %b want 0", busy); else passes++;
        checks++; if (meas_count !== 8'(m_meas)) $display("FAIL en_drop_meas got %0d want %0d", meas_count, m_meas); else passes++;
        @(negedge clk); enable = 1'b1;

        // Trigger still high when the responder returns to IDLE must not be accepted.
        errs = 0; seen = 1'b0; bseen = 1'b0;
        trigger_in = 1'b1;
        repeat (20) @(negedge clk);
        enable = 1'b0;
        @(negedge clk); enable = 1'b1;
        repeat (40) @(negedge clk);
        trigger_in = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            errs += int'(trig_err);
            seen |= echo_out;
            bseen |= busy;
        end
        checks++; if (seen !== 1'b0) $display("FAIL held_trig_echo got %b want 0", seen); else passes++;
        checks++; if (bseen !== 1'b0) $display("FAIL held_trig_busy got %b want 0", bseen); else passes++;
        checks++; if (meas_count !== 8'(m_meas)) $display("FAIL held_trig_meas got %0d want %0d", meas_count, m_meas); else passes++;
    endtask

    task automatic test_random;
        int d, n, w, lat, wid, c;
        for (int k = 0; k < 6; k++) begin
            d = int'($urandom_range(0, 511));
            n = int'($urandom_range(TMIN * CYC, TMIN * CYC + 30));
            distance_cm = 9'(d);
            w = accept_model(d);
            send_trig(n);
            measure_echo(lat, wid);
            checks++; if (lat !== LAT) $display("FAIL rand%0d_latency got %0d want %0d", k, lat, LAT); else passes++;
            checks++; if (wid !== w * CYC) $display("FAIL rand%0d_width d=%0d got %0d want %0d", k, d, wid, w * CYC); else passes++;
            checks++; if (meas_count !== 8'(m_meas)) $display("FAIL rand%0d_meas got %0d want %0d", k, meas_count, m_meas); else passes++;
            wait_idle(c);
            checks++; if (c !== HOLD * CYC) $display("FAIL rand%0d_holdoff got %0d want %0d", k, c, HOLD * CYC); else passes++;
        end
    endtask

    task automatic test_reset_mid;
        int w, lat;
        distance_cm = 9'd20;
        w = accept_model(20);
        send_trig(24);
        wait_rise(lat);
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++; if (echo_out !== 1'b0) $display("FAIL midreset_echo got %b want 0", echo_out); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", busy); else passes++;
        checks++; if (trig_err !== 1'b0) $display("FAIL midreset_err got %b want 0", trig_err); else passes++;
        checks++; if (meas_count !== 8'd0) $display("FAIL midreset_meas got %0d want 0", meas_count); else passes++;
        m_meas = 0;
        m_lfsr = 8'hA5;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_wrap;
        int w;
        for (int k = 1; k <= 256; k++) begin
            distance_cm = 9'($urandom_range(1, 400));
            w = accept_model(int'(distance_cm));
            send_trig(TMIN * CYC);
            repeat (6) @(posedge clk);
            @(negedge clk); enable = 1'b0;
            @(negedge clk); enable = 1'b1;
            if (k == 255) begin
                #1;
                checks++; if (meas_count !== 8'd255) $display("FAIL wrap_255 got %0d want 255", meas_count); else passes++;
            end
        end
        #1;
        checks++; if (meas_count !== 8'(m_meas)) $display("FAIL wrap_0 got %0d want %0d", meas_count, m_meas); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL wrap_busy got %b want 0", busy); else passes++;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset;
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b1;
        repeat (4) @(posedge clk);
        test_basic;
        test_short;
        test_range;
        test_holdoff;
        test_latch_enable;
        test_random;
        test_reset_mid;
        test_wrap;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
